// File: rtl/gate_test_pkg.sv
// Shared types and reference truth tables for the 2-input gate exerciser.
// Latency: none (declarations only).
// Backpressure: not applicable.
package gate_test_pkg;

  // Sweep controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Truth tables indexed by {i1,i0}: bit[{i1,i0}] is the gate output.
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_truth_checker_settle_counter.sv
// Loadable down-counter with a zero flag, paces how long each vector is held.
// Latency: load/decrement visible one cycle after the edge; zero is combinational on the count.
// Backpressure: none; decrement saturates at zero.
module settle_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins over decrement; never underflows.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps {i1,i0}=00..11 into a 2-input gate, samples each after settling, compares to EXPECTED.
// Latency: start accept to done = 4*(SETTLE_CYCLES+1)+1 cycles.
// Backpressure: start is ignored while busy; no queueing of requests.
module gate_truth_checker
  import gate_test_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [3:0] EXPECTED      = TT_NOR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       drv_i1,
  output logic       drv_i0,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] observed,
  output logic [3:0] fail_mask
);

  // Counter wide enough to hold SETTLE_CYCLES-1; clamp keeps width legal if the check below fires.
  localparam int            CW     = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("gate_truth_checker: SETTLE_CYCLES must be >= 1");
  end

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] drv_q, drv_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] observed_q, observed_d;
  logic [3:0] fail_mask_q, fail_mask_d;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;

  settle_counter #(.W(CW)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (RELOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Sweep sequencing: next state, drive vector, capture and result registers.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    drv_d       = drv_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    observed_d  = observed_q;
    fail_mask_d = fail_mask_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d       = 2'd0;
          drv_d       = 2'b00;
          cnt_load    = 1'b1;
          observed_d  = 4'b0000;
          fail_mask_d = 4'b0000;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d = SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SAMPLE: begin
        observed_d[idx_q] = dut_out;
        if (idx_q == 2'd3) begin
          state_d = DONE;
        end else begin
          idx_d    = idx_q + 2'd1;
          drv_d    = idx_q + 2'd1;
          cnt_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      DONE: begin
        done_d      = 1'b1;
        pass_d      = (observed_q == EXPECTED);
        fail_mask_d = observed_q ^ EXPECTED;
        busy_d      = 1'b0;
        drv_d       = 2'b00;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sweep and drops partial results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      drv_q       <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      observed_q  <= 4'b0000;
      fail_mask_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      drv_q       <= drv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      observed_q  <= observed_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign drv_i1    = drv_q[1];
  assign drv_i0    = drv_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign observed  = observed_q;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Randomized scoreboard bench: two checkers (settle 1 / NOR, settle 3 / NAND) driving modelled gates.
// Latency: expected done edge derived from accept edge + 4*(settle+1)+1.
// Backpressure: model ignores starts until its own notion of the sweep has finished.
module tb_gate_truth_checker;

  localparam int G_NOR = 0, G_OR = 1, G_AND = 2, G_NAND = 3, G_XOR = 4, G_XNOR = 5;
  localparam int         SC   [2] = '{1, 3};
  localparam logic [3:0] EXPV [2] = '{4'b0001, 4'b0111};

  typedef struct {
    int         inst;
    int         done_edge;
    logic [3:0] obs;
    logic       pas;
    logic [3:0] fm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic [1:0] dut_out;
  logic [1:0] drv_i1, drv_i0, busy, done, pass;
  logic [3:0] observed  [2];
  logic [3:0] fail_mask [2];
  int         gsel      [2];

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rst_edge = -1;
  int   acc_edge  [2] = '{0, 0};
  int   next_free [2] = '{0, 0};
  bit   have      [2] = '{1'b0, 1'b0};
  logic exp_pass  [2];
  logic [3:0] exp_fm [2];
  exp_t sbq [$];
  bit   fin_req = 1'b0;
  bit   fin_ack = 1'b0;

  gate_truth_checker #(.SETTLE_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .dut_out(dut_out[0]),
    .drv_i1(drv_i1[0]), .drv_i0(drv_i0[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .observed(observed[0]), .fail_mask(fail_mask[0])
  );

  gate_truth_checker #(.SETTLE_CYCLES(3), .EXPECTED(4'b0111)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .dut_out(dut_out[1]),
    .drv_i1(drv_i1[1]), .drv_i0(drv_i0[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .observed(observed[1]), .fail_mask(fail_mask[1])
  );

  initial forever #5 clk = ~clk;

  // Behavioural gate: a = i1, b = i0, plain arithmetic on the inputs.
  function automatic logic gate_ref(int kind, int a, int b);
    case (kind)
      G_NOR:   return (a + b) == 0;
      G_OR:    return (a + b) > 0;
      G_AND:   return (a * b) == 1;
      G_NAND:  return (a * b) == 0;
      G_XOR:   return (a + b) == 1;
      default: return a == b;
    endcase
  endfunction

  // Gates under test attached to each checker's drive outputs.
  always_comb begin
    dut_out = 2'b00;
    for (int g = 0; g < 2; g++)
      dut_out[g] = gate_ref(gsel[g], int'(drv_i1[g]), int'(drv_i0[g]));
  end

  task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d edge %0d: got %0h expected %0h", nm, g, cyc - 1, act, exp);
    end
  endtask

  // Reference model: decides acceptance and pushes the expected result per sweep.
  always @(posedge clk) begin
    exp_t       x;
    logic [3:0] tbl;
    if (rst) begin
      sbq.delete();
      rst_edge <= cyc;
      for (int g = 0; g < 2; g++) begin
        have[g]      <= 1'b0;
        next_free[g] <= 0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (start[g] && cyc >= next_free[g]) begin
          for (int v = 0; v < 4; v++) tbl[v] = gate_ref(gsel[g], v / 2, v % 2);
          x.inst      = g;
          x.done_edge = cyc + 4 * (SC[g] + 1) + 1;
          x.obs       = tbl;
          x.pas       = (tbl == EXPV[g]);
          x.fm        = tbl ^ EXPV[g];
          sbq.push_back(x);
          exp_pass[g]  <= x.pas;
          exp_fm[g]    <= x.fm;
          acc_edge[g]  <= cyc;
          have[g]      <= 1'b1;
          next_free[g] <= cyc + 4 * (SC[g] + 1) + 2;
        end
      end
    end
    cyc <= cyc + 1;
  end

  // Monitor: per-cycle drive/busy/result checks and scoreboard pop on done.
  always @(negedge clk) begin
    int         e, k, L, pos;
    logic [1:0] edrv;
    logic       ebusy, epass;
    logic [3:0] efm;
    e = cyc - 1;
    for (int g = 0; g < 2; g++) begin
      L = 4 * (SC[g] + 1);
      edrv = 2'b00; ebusy = 1'b0; epass = 1'b0; efm = 4'b0000;
      if (have[g]) begin
        k = e - acc_edge[g];
        if (k < L) edrv = 2'(k / (SC[g] + 1));
        else if (k == L) edrv = 2'd3;
        ebusy = (k <= L);
        if (k > L) begin
          epass = exp_pass[g];
          efm   = exp_fm[g];
        end
      end
      chk("drive", g, 32'({drv_i1[g], drv_i0[g]}), 32'(edrv));
      chk("busy", g, 32'(busy[g]), 32'(ebusy));
      chk("pass_held", g, 32'(pass[g]), 32'(epass));
      chk("fail_mask_held", g, 32'(fail_mask[g]), 32'(efm));
      if (rst_edge == e) begin
        chk("rst_observed", g, 32'(observed[g]), 32'(0));
        chk("rst_done", g, 32'(done[g]), 32'(0));
      end
      pos = -1;
      for (int i = 0; i < sbq.size(); i++) begin
        if (sbq[i].inst == g) begin
          pos = i;
          break;
        end
      end
      if (done[g]) begin
        if (pos < 0) begin
          chk("spurious_done", g, 32'(1), 32'(0));
        end else begin
          chk("done_edge", g, 32'(e), 32'(sbq[pos].done_edge));
          chk("observed", g, 32'(observed[g]), 32'(sbq[pos].obs));
          chk("pass", g, 32'(pass[g]), 32'(sbq[pos].pas));
          chk("fail_mask", g, 32'(fail_mask[g]), 32'(sbq[pos].fm));
          sbq.delete(pos);
        end
      end else if (pos >= 0 && e > sbq[pos].done_edge) begin
        chk("done_missing", g, 32'(e), 32'(sbq[pos].done_edge));
        sbq.delete(pos);
      end
    end
    if (fin_req && !fin_ack) begin
      chk("pending_results", 0, 32'(sbq.size()), 32'(0));
      fin_ack = 1'b1;
    end
  end

  task automatic wait_idle(int g);
    for (int i = 0; i < 100 && cyc < next_free[g]; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(int g, int n);
    start[g] = 1'b1;
    repeat (n) @(negedge clk);
    start[g] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 2'b00;
    gsel[0] = G_NOR;
    gsel[1] = G_NAND;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // NOR against NOR, then OR against NOR, then NAND with settle 3.
    pulse(0, 1); wait_idle(0);
    gsel[0] = G_OR;
    pulse(0, 1); wait_idle(0);
    pulse(1, 1); wait_idle(1);

    // Reset on the edge that samples vector 10, then a clean sweep.
    gsel[0] = G_NOR;
    pulse(0, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse(0, 1); wait_idle(0);

    // Mid-sweep start is ignored; held start gives back-to-back sweeps.
    pulse(0, 1);
    repeat (3) @(negedge clk);
    pulse(0, 1);
    wait_idle(0);
    pulse(0, 25); wait_idle(0);

    // Output high only for vector 11.
    gsel[0] = G_AND;
    pulse(0, 1); wait_idle(0);

    // Randomized gates, gaps, pulse widths and extra mid-sweep pulses.
    for (int it = 0; it < 24; it++) begin
      int g;
      g = int'($urandom_range(1, 0));
      wait_idle(g);
      gsel[g] = int'($urandom_range(5, 0));
      repeat ($urandom_range(2, 0)) @(negedge clk);
      pulse(g, int'($urandom_range(3, 1)));
      if ($urandom_range(1, 0) == 1) begin
        repeat (2) @(negedge clk);
        pulse(g, 1);
      end
    end
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);
    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_ack; i++) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
